// File: rtl/alu_pkg.sv
// Shared types for the ALU op sequencer: operation encodings and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_div_step.sv
// One combinational step of an unsigned restoring divide.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, shifting the resulting quotient bit in at the bottom.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; rem_in < divisor keeps a non-negative diff within WIDTH bits.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: single-cycle ops complete in one edge, DIV iterates a
// restoring step WIDTH times. Valid/ready handshake on both request and
// response, with back-to-back accept while a finished response retires.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  seq_state_t       state_q, state_d;
  alu_sel_t         sel;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;     // quotient accumulator while dividing
  logic [WIDTH-1:0] remainder_q;  // partial remainder while dividing
  logic [WIDTH-1:0] divisor_q;
  logic             dbz_q;
  logic             accept;
  logic             is_div;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign sel        = alu_sel_t'(alu_sel);
  assign is_div     = (sel == ALU_DIV);
  assign req_ready  = (state_q == IDLE) | ((state_q == DONE) & resp_ready);
  assign accept     = req_valid & req_ready & ~flush;
  assign resp_valid = (state_q == DONE);
  assign result     = result_q;
  assign remainder  = remainder_q;
  assign zero       = (state_q == DONE) & (result_q == '0);
  assign div_by_zero = (state_q == DONE) & dbz_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (remainder_q),
    .quo_in  (result_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Single-cycle operation results, truncated to WIDTH.
  always_comb begin
    alu_out = '0;
    case (sel)
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_MUL: alu_out = op_a * op_b;
      ALU_AND: alu_out = op_a & op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_SLL: alu_out = op_a << op_b[CW-1:0];
      ALU_SRL: alu_out = op_a >> op_b[CW-1:0];
      default: alu_out = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (is_div && op_b != '0) ? DIV : DONE;
      end
      DIV: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (accept)          state_d = (is_div && op_b != '0) ? DIV : DONE;
        else if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operand capture, single-cycle results and divide iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (is_div && op_b == '0) begin
        result_q    <= '1;
        remainder_q <= op_a;
        dbz_q       <= 1'b1;
      end else if (is_div) begin
        result_q    <= op_a;
        remainder_q <= '0;
        cnt_q       <= CNT_LAST;
        dbz_q       <= 1'b0;
      end else begin
        result_q    <= alu_out;
        remainder_q <= '0;
        dbz_q       <= 1'b0;
      end
    end else if (state_q == DIV && !flush) begin
      result_q    <= step_quo;
      remainder_q <= step_rem;
      cnt_q       <= cnt_q - 1'b1;
    end
  end

  // Divisor only matters while dividing, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) divisor_q <= op_b;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_op_sequencer;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rem;
    logic             z;
    logic             dbz;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       alu_sel = 3'b000;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             zero;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .alu_sel     (alu_sel),
    .op_a        (op_a),
    .op_b        (op_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .result      (result),
    .remainder   (remainder),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive a request (called just after a rising edge) and hold it until accepted.
  task automatic send(input logic [2:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit push, input exp_t e);
    int n;
    req_valid = 1'b1;
    alu_sel   = sel;
    op_a      = a;
    op_b      = b;
    if (push) sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready %b expected 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m, input logic d);
    exp_t e;
    e.res = r;
    e.rem = m;
    e.z   = (r == '0);
    e.dbz = d;
    return e;
  endfunction

  // Monitor: every completed response handshake must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: result %h with empty scoreboard", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("remainder", remainder, e.rem);
          chk("zero", WIDTH'(zero), WIDTH'(e.z));
          chk("div_by_zero", WIDTH'(div_by_zero), WIDTH'(e.dbz));
        end
      end
    end
  end

  initial begin
    exp_t none;
    none = '0;

    // Reset state
    #2;
    chk("rst_req_ready", WIDTH'(req_ready), 1);
    chk("rst_resp_valid", WIDTH'(resp_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_zero", WIDTH'(zero), 0);
    chk("rst_dbz", WIDTH'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. add and sub with zero flag
    send(3'b000, 32'd7, 32'd5, 1, mk(32'd12, 0, 0));
    @(negedge clk);
    chk("add_latency", WIDTH'(resp_valid), 1);
    @(posedge clk);
    #1;
    send(3'b001, 32'd5, 32'd5, 1, mk(32'd0, 0, 0));
    @(negedge clk);
    chk("sub_latency", WIDTH'(resp_valid), 1);
    @(posedge clk);
    #1;

    // 2. div 100/7: busy for WIDTH cycles
    send(3'b011, 32'd100, 32'd7, 1, mk(32'd14, 32'd2, 0));
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk("div_busy", WIDTH'({req_ready, resp_valid}), 0);
    end
    @(negedge clk);
    chk("div_latency", WIDTH'(resp_valid), 1);
    @(posedge clk);
    #1;

    // 3. divide by zero
    send(3'b011, 32'd9, 32'd0, 1, mk(32'hFFFF_FFFF, 32'd9, 1));
    @(negedge clk);
    chk("dbz_latency", WIDTH'(resp_valid), 1);
    @(posedge clk);
    #1;

    // 4. stall in DONE, then back-to-back accept
    resp_ready = 1'b0;
    send(3'b000, 32'd3, 32'd4, 1, mk(32'd7, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", WIDTH'(resp_valid), 1);
      chk("stall_result", result, 32'd7);
      chk("stall_req_ready", WIDTH'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    send(3'b000, 32'd1, 32'd1, 1, mk(32'd2, 0, 0));
    @(negedge clk);
    chk("b2b_valid", WIDTH'(resp_valid), 1);
    chk("b2b_result", result, 32'd2);
    @(posedge clk);
    #1;

    // 5. flush during the 10th DIV cycle
    send(3'b011, 32'd1000, 32'd3, 0, none);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_resp_valid", WIDTH'(resp_valid), 0);
    chk("flush_req_ready", WIDTH'(req_ready), 1);
    @(posedge clk);
    #1;
    send(3'b010, 32'd3, 32'd4, 1, mk(32'd12, 0, 0));
    @(posedge clk);
    #1;

    // 6. async reset mid-DIV
    send(3'b011, 32'd100, 32'd7, 0, none);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", WIDTH'(req_ready), 1);
    chk("mid_rst_resp_valid", WIDTH'(resp_valid), 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'b110, 32'd1, 32'd31, 1, mk(32'h8000_0000, 0, 0));
    send(3'b111, 32'h8000_0000, 32'd31, 1, mk(32'd1, 0, 0));

    // Drain
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", WIDTH'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
